// File: rtl/acc_quant_v3.sv
// Per-column partial-sum accumulator with requantization to DATA_WIDTH.
// Lanes run independently under a shared IDLE/RUN/DONE job controller.
module acc_quant_v3 #(
  parameter int unsigned PE_SIZE    = 14,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PSUM_WIDTH = 32,
  parameter int unsigned MAX_DEPTH  = 128,
  parameter int unsigned DEPTH_W    = 8,
  parameter int unsigned PASS_W     = 16,
  parameter int unsigned SHIFT_W    = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_start_i,
  input  logic [DEPTH_W-1:0]             cfg_depth_i,
  input  logic [PASS_W-1:0]              cfg_pass_i,
  input  logic [SHIFT_W-1:0]             cfg_shift_i,
  input  logic                           cfg_relu_i,
  input  logic [PE_SIZE-1:0]             psum_en_row_i,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0]  psum_row_i,
  output logic [DATA_WIDTH*PE_SIZE-1:0]  ofmap_row_o,
  output logic [PE_SIZE-1:0]             ofmap_valid_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int unsigned PTR_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic signed [PSUM_WIDTH-1:0] Q_MAX = PSUM_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [PSUM_WIDTH-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DEPTH_W-1:0]     depth_q;
  logic [PASS_W-1:0]      pass_q;
  logic [SHIFT_W-1:0]     shift_q;
  logic                   relu_q;
  logic [PTR_W-1:0]       ptr_q  [PE_SIZE];
  logic [PASS_W-1:0]      pcnt_q [PE_SIZE];
  logic [PE_SIZE-1:0]     done_q;
  logic [PSUM_WIDTH-1:0]  mem    [PE_SIZE][MAX_DEPTH];

  logic [PE_SIZE-1:0]     hit, last_entry, final_pass, finish;
  logic [PSUM_WIDTH-1:0]  psum [PE_SIZE];
  logic [PSUM_WIDTH-1:0]  sum  [PE_SIZE];
  logic [DATA_WIDTH-1:0]  qval [PE_SIZE];
  logic                   cfg_ok, start_ok, err_set;

  function automatic logic [DATA_WIDTH-1:0] quantize(input logic [PSUM_WIDTH-1:0] s,
                                                     input logic [SHIFT_W-1:0]    sh,
                                                     input logic                  relu);
    logic signed [PSUM_WIDTH-1:0] v;
    v = $signed(s) >>> sh;
    if (relu && v[PSUM_WIDTH-1]) v = '0;
    if (v > Q_MAX)      v = Q_MAX;
    else if (v < Q_MIN) v = Q_MIN;
    return v[DATA_WIDTH-1:0];
  endfunction

  // Pass 0 ignores storage so stale contents from an aborted job never leak in.
  always_comb begin
    for (int unsigned j = 0; j < PE_SIZE; j++) begin
      psum[j]       = psum_row_i[PSUM_WIDTH*j +: PSUM_WIDTH];
      hit[j]        = (state_q == RUN) && psum_en_row_i[j] && !done_q[j];
      last_entry[j] = (DEPTH_W'(ptr_q[j]) == depth_q - 1'b1);
      final_pass[j] = (pcnt_q[j] == pass_q - 1'b1);
      finish[j]     = hit[j] && last_entry[j] && final_pass[j];
      sum[j]        = (pcnt_q[j] == '0) ? psum[j] : mem[j][ptr_q[j]] + psum[j];
      qval[j]       = quantize(sum[j], shift_q, relu_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    cfg_ok   = (cfg_depth_i != '0) && (cfg_depth_i <= DEPTH_W'(MAX_DEPTH)) && (cfg_pass_i != '0);
    start_ok = (state_q == IDLE) && cfg_start_i && cfg_ok;
    err_set  = ((state_q != RUN) && (|psum_en_row_i)) ||
               ((state_q == RUN) && (|(psum_en_row_i & done_q))) ||
               ((state_q == IDLE) && cfg_start_i && !cfg_ok);
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (&(done_q | finish)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      depth_q       <= '0;
      pass_q        <= '0;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      done_q        <= '0;
      err_o         <= 1'b0;
      ofmap_valid_o <= '0;
      ofmap_row_o   <= '0;
      for (int unsigned j = 0; j < PE_SIZE; j++) begin
        ptr_q[j]  <= '0;
        pcnt_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (err_set)       err_o <= 1'b1;
      else if (start_ok) err_o <= 1'b0;
      if (start_ok) begin
        depth_q <= cfg_depth_i;
        pass_q  <= cfg_pass_i;
        shift_q <= cfg_shift_i;
        relu_q  <= cfg_relu_i;
        done_q  <= '0;
        for (int unsigned j = 0; j < PE_SIZE; j++) begin
          ptr_q[j]  <= '0;
          pcnt_q[j] <= '0;
        end
      end else begin
        for (int unsigned j = 0; j < PE_SIZE; j++) begin
          if (hit[j]) begin
            if (last_entry[j]) begin
              ptr_q[j] <= '0;
              if (final_pass[j]) done_q[j] <= 1'b1;
              else               pcnt_q[j] <= pcnt_q[j] + 1'b1;
            end else begin
              ptr_q[j] <= ptr_q[j] + 1'b1;
            end
          end
        end
      end
      for (int unsigned j = 0; j < PE_SIZE; j++) begin
        ofmap_valid_o[j] <= hit[j] && final_pass[j];
        ofmap_row_o[DATA_WIDTH*j +: DATA_WIDTH] <= (hit[j] && final_pass[j]) ? qval[j] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < PE_SIZE; j++) begin
      if (hit[j] && !final_pass[j]) mem[j][ptr_q[j]] <= sum[j];
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_acc_quant_v3.sv
// Randomized and directed checks of acc_quant_v3 against a strobe-counting reference model.
module tb_acc_quant_v3;

  localparam int PE = 14, DW = 8, PW = 32, MD = 128, DEPW = 8, PASSW = 16, SHW = 5;
  localparam int BUDGET = 4000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cfg_start_i;
  logic [DEPW-1:0]     cfg_depth_i;
  logic [PASSW-1:0]    cfg_pass_i;
  logic [SHW-1:0]      cfg_shift_i;
  logic                cfg_relu_i;
  logic [PE-1:0]       psum_en_row_i;
  logic [PW*PE-1:0]    psum_row_i;
  logic [DW*PE-1:0]    ofmap_row_o;
  logic [PE-1:0]       ofmap_valid_o;
  logic                busy_o, done_o, err_o;

  always #5 clk = ~clk;

  acc_quant_v3 #(
    .PE_SIZE(PE), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .MAX_DEPTH(MD),
    .DEPTH_W(DEPW), .PASS_W(PASSW), .SHIFT_W(SHW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start_i(cfg_start_i), .cfg_depth_i(cfg_depth_i),
    .cfg_pass_i(cfg_pass_i), .cfg_shift_i(cfg_shift_i), .cfg_relu_i(cfg_relu_i),
    .psum_en_row_i(psum_en_row_i), .psum_row_i(psum_row_i), .ofmap_row_o(ofmap_row_o),
    .ofmap_valid_o(ofmap_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int n_total = 0, n_bad = 0;

  // Reference model: phase 0 idle, 1 job running, 2 job just completed.
  int  m_phase, m_depth, m_pass, m_shift;
  bit  m_err, m_relu;
  int  cnt [PE];
  int  acc [PE][MD];
  logic [PE-1:0]    exp_valid;
  logic [DW*PE-1:0] exp_row;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mq(input int s, input int sh, input bit relu);
    longint d, q;
    d = longint'(1) << sh;
    q = longint'(s) / d;
    if ((longint'(s) % d) != 0 && s < 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q[DW-1:0];
  endfunction

  function automatic int lane_psum(input int j);
    return int'(psum_row_i[PW*j +: PW]);
  endfunction

  task automatic step();
    int need, e, p;
    bit ok, all_done;
    exp_valid = '0;
    exp_row   = '0;
    ok = (cfg_depth_i >= 1) && (int'(cfg_depth_i) <= MD) && (cfg_pass_i >= 1);
    case (m_phase)
      0: begin
        if (cfg_start_i) begin
          if (ok) begin
            m_err = 0; m_phase = 1;
            m_depth = int'(cfg_depth_i); m_pass = int'(cfg_pass_i);
            m_shift = int'(cfg_shift_i); m_relu = cfg_relu_i;
            for (int j = 0; j < PE; j++) cnt[j] = 0;
          end else m_err = 1;
        end
        if (|psum_en_row_i) m_err = 1;
      end
      1: begin
        need = m_depth * m_pass;
        all_done = 1;
        for (int j = 0; j < PE; j++) begin
          if (psum_en_row_i[j]) begin
            if (cnt[j] < need) begin
              e = cnt[j] % m_depth;
              p = cnt[j] / m_depth;
              if (p == 0) acc[j][e] = lane_psum(j);
              else        acc[j][e] = acc[j][e] + lane_psum(j);
              if (p == m_pass - 1) begin
                exp_valid[j] = 1'b1;
                exp_row[DW*j +: DW] = mq(acc[j][e], m_shift, m_relu);
              end
              cnt[j]++;
            end else m_err = 1;
          end
          if (cnt[j] < need) all_done = 0;
        end
        if (all_done) m_phase = 2;
      end
      default: begin
        if (|psum_en_row_i) m_err = 1;
        m_phase = 0;
      end
    endcase
    @(posedge clk);
    #1;
    check_eq("valid", ofmap_valid_o, exp_valid);
    check_eq("row",   ofmap_row_o,   exp_row);
    check_eq("busy",  busy_o,        m_phase == 1);
    check_eq("done",  done_o,        m_phase == 2);
    check_eq("err",   err_o,         m_err);
    cfg_start_i   = 1'b0;
    psum_en_row_i = '0;
  endtask

  task automatic start_job(input int d, input int p, input int sh, input bit r);
    cfg_depth_i = DEPW'(d); cfg_pass_i = PASSW'(p);
    cfg_shift_i = SHW'(sh); cfg_relu_i = r;
    cfg_start_i = 1'b1;
    step();
  endtask

  task automatic lane0(input int v);
    psum_en_row_i = 1;
    psum_row_i[PW-1:0] = v;
    step();
  endtask

  function automatic int rnd_psum();
    if ($urandom_range(0, 1) == 1) return int'($urandom);
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  // Finishes the current job; extra > 0 occasionally strobes lanes that are already done.
  task automatic drain(input int extra);
    int n = 0;
    while (m_phase != 0 && n < BUDGET) begin
      for (int j = 0; j < PE; j++) begin
        if (m_phase == 1 && cnt[j] < m_depth * m_pass) psum_en_row_i[j] = ($urandom_range(0, 1) == 1);
        else psum_en_row_i[j] = (extra > 0) && ($urandom_range(0, 15) == 0);
        psum_row_i[PW*j +: PW] = rnd_psum();
      end
      step();
      n++;
    end
    if (n >= BUDGET) check_eq("drain_timeout", busy_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p;
    rst_n = 1'b0; cfg_start_i = 1'b0; cfg_depth_i = '0; cfg_pass_i = '0;
    cfg_shift_i = '0; cfg_relu_i = 1'b0; psum_en_row_i = '0; psum_row_i = '0;
    m_phase = 0; m_err = 0; m_depth = 1; m_pass = 1; m_shift = 0; m_relu = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_valid", ofmap_valid_o, '0);
    check_eq("rst_row",   ofmap_row_o,   '0);
    check_eq("rst_busy",  busy_o, 1'b0);
    check_eq("rst_done",  done_o, 1'b0);
    check_eq("rst_err",   err_o,  1'b0);

    // pass=1: direct output
    start_job(2, 1, 0, 0);
    lane0(5);   check_eq("p1_first",  ofmap_row_o[DW-1:0], 8'h05);
    lane0(-3);  check_eq("p1_second", ofmap_row_o[DW-1:0], 8'hFD);
    drain(0);

    // depth=1, pass=3 saturation and shift
    start_job(1, 3, 0, 0);
    lane0(100); lane0(100); lane0(100); check_eq("sat_pos", ofmap_row_o[DW-1:0], 8'h7F);
    drain(0);
    start_job(1, 3, 2, 0);
    lane0(100); lane0(100); lane0(100); check_eq("shift2", ofmap_row_o[DW-1:0], 8'h4B);
    drain(0);
    start_job(1, 3, 0, 0);
    lane0(-100); lane0(-100); lane0(-100); check_eq("sat_neg", ofmap_row_o[DW-1:0], 8'h80);
    drain(0);

    // ReLU vs floor shift
    start_job(1, 2, 3, 1);
    lane0(-20); lane0(-20); check_eq("relu", ofmap_row_o[DW-1:0], 8'h00);
    check_eq("relu_valid", ofmap_valid_o[0], 1'b1);
    drain(0);
    start_job(1, 2, 3, 0);
    lane0(-20); lane0(-20); check_eq("floor_neg", ofmap_row_o[DW-1:0], 8'hFB);
    drain(0);

    // Skewed lanes, depth=4 pass=2
    start_job(4, 2, $urandom_range(0, 24), $urandom_range(0, 1));
    for (int s = 0; s < PE + 7; s++) begin
      for (int j = 0; j < PE; j++) begin
        psum_en_row_i[j] = (s >= j) && (s < j + 8);
        psum_row_i[PW*j +: PW] = rnd_psum();
      end
      step();
    end
    check_eq("skew_done", done_o, 1'b1);
    check_eq("skew_lastvalid", ofmap_valid_o[PE-1], 1'b1);
    drain(0);

    // Error protocol
    psum_en_row_i = 1; step();
    check_eq("idle_strobe_err", err_o, 1'b1);
    start_job(0, 1, 0, 0);
    check_eq("depth0_busy", busy_o, 1'b0);
    start_job(1, 1, 0, 0);
    check_eq("start_clears_err", err_o, 1'b0);
    lane0(7); lane0(9);
    check_eq("done_lane_err", err_o, 1'b1);
    drain(0);
    // start coincident with strobe
    cfg_depth_i = 2; cfg_pass_i = 1; cfg_shift_i = 0; cfg_relu_i = 0;
    cfg_start_i = 1'b1; psum_en_row_i = 1; step();
    check_eq("coinc_err", err_o, 1'b1);
    drain(0);

    // Reset mid-job, then a fresh job over stale storage
    start_job(2, 3, 0, 0);
    for (int j = 0; j < PE; j++) psum_row_i[PW*j +: PW] = 32'd50;
    psum_en_row_i = '1; step();
    rst_n = 1'b0; #1;
    check_eq("midrst_valid", ofmap_valid_o, '0);
    check_eq("midrst_busy",  busy_o, 1'b0);
    m_phase = 0; m_err = 0;
    @(negedge clk) rst_n = 1'b1;
    start_job(2, 2, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < PE; j++) psum_row_i[PW*j +: PW] = k;
      psum_en_row_i = '1; step();
    end
    check_eq("fresh_done", done_o, 1'b1);
    drain(0);

    // Randomized jobs
    for (int job = 0; job < 24; job++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: start_job(0, 2, 0, 0);
          1: start_job(200, 1, 0, 0);
          default: start_job(3, 0, 0, 0);
        endcase
      end
      if ($urandom_range(0, 3) == 0) begin
        psum_en_row_i = PE'($urandom) | 1; step();
      end
      d = ($urandom_range(0, 9) == 0) ? MD : $urandom_range(1, 6);
      p = $urandom_range(1, 3);
      start_job(d, p, $urandom_range(0, 24), $urandom_range(0, 1));
      drain(1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
